// File: rtl/decode_uop_sequencer.sv
// decode_uop_sequencer
// Registered, handshaked main decoder at the IF->ID boundary of the RV32 core.
// Each accepted instruction is decoded into the ID control bundle and appears
// on registered outputs one cycle later. With FUSED_SPLIT set, the R4-type fused
// FP ops are cracked into two micro-ops, a multiply and then an add/sub, so a
// single-op FPU can execute them.
module decode_uop_sequencer #(
   parameter bit FP_EN       = 1'b1,
   parameter bit FUSED_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr_o,
   output logic        reg_write,
   output logic        mem_write,
   output logic        branch,
   output logic        jump,
   output logic        alu_src_a,
   output logic        fp_sel,
   output logic [2:0]  imm_src,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_op,
   output logic [1:0]  fp_op,
   output logic        fp_neg,
   output logic        uop_last,
   output logic        illegal
);

   // Sequencer states: EMPTY holds nothing, FULL holds one uop (the last or only
   // uop of an instruction), SPLIT holds uop0 of a cracked fused op.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SPLIT = 2'd2
   } stateT;

   // Field order matches the documented bundle bit strings, so each decode
   // table entry below is written exactly as a 15-bit pattern.
   typedef struct packed {
      logic       regWrite;
      logic [2:0] immSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       memWrite;
      logic [1:0] resultSrc;
      logic       branch;
      logic [1:0] aluOp;
      logic       jump;
      logic       fpSel;
   } ctrlT;

   // Major opcodes
   localparam logic [6:0] OP_BUBBLE = 7'b0000000;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FLW    = 7'b0000111;
   localparam logic [6:0] OP_FSW    = 7'b0100111;
   localparam logic [6:0] OP_FP     = 7'b1010011;
   localparam logic [6:0] OP_FMADD  = 7'b1000011;
   localparam logic [6:0] OP_FMSUB  = 7'b1000111;
   localparam logic [6:0] OP_FNMSUB = 7'b1001011;
   localparam logic [6:0] OP_FNMADD = 7'b1001111;

   // Control bundles, laid out as {regWrite,immSrc,aluSrcA,aluSrcB,memWrite,
   // resultSrc,branch,aluOp,jump,fpSel}
   localparam ctrlT CTRL_LW    = 15'b1_000_0_01_0_01_0_00_0_0;
   localparam ctrlT CTRL_SW    = 15'b0_001_0_01_1_00_0_00_0_0;
   localparam ctrlT CTRL_R     = 15'b1_000_0_00_0_00_0_10_0_0;
   localparam ctrlT CTRL_B     = 15'b0_010_0_00_0_00_1_01_0_0;
   localparam ctrlT CTRL_I     = 15'b1_000_0_01_0_00_0_10_0_0;
   localparam ctrlT CTRL_JAL   = 15'b1_011_0_00_0_10_0_00_1_0;
   localparam ctrlT CTRL_AUIPC = 15'b1_100_1_10_0_00_0_00_0_0;
   localparam ctrlT CTRL_LUI   = 15'b1_100_1_01_0_00_0_00_0_0;
   localparam ctrlT CTRL_JALR  = 15'b1_000_0_01_0_10_0_00_1_0;
   localparam ctrlT CTRL_FLW   = 15'b1_000_0_01_0_01_0_00_0_1;
   localparam ctrlT CTRL_FSW   = 15'b0_001_0_01_1_00_0_00_0_1;
   localparam ctrlT CTRL_FP    = 15'b1_000_0_00_0_00_0_10_0_1;

   // FP unit operation selects
   localparam logic [1:0] FPOP_FUNCT = 2'b00;
   localparam logic [1:0] FPOP_MUL   = 2'b01;
   localparam logic [1:0] FPOP_ADD   = 2'b10;
   localparam logic [1:0] FPOP_SUB   = 2'b11;

   stateT      state;
   stateT      nextState;

   // Decode of the incoming instruction
   ctrlT       decCtrl;
   logic       decIllegal;
   logic       decFused;
   logic       decIsFp;
   logic       decSplit;

   // Handshake qualifiers
   logic       inReadyInt;
   logic       loadNew;
   logic       advanceSplit;

   // Output registers
   ctrlT       ctrlQ;
   logic [31:0] instrQ;
   logic       illegalQ;
   logic [1:0] fpOpQ;
   logic       fpNegQ;
   logic       uopLastQ;
   logic       outValidQ;

   // Second-uop controls of a cracked fused op, taken from the held instruction:
   // opcode bits [3:2] are 00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD.
   logic       fusedSub;
   logic       fusedNeg;

   assign fusedSub = instrQ[3] ^ instrQ[2];
   assign fusedNeg = instrQ[3];

   // Combinational main decode of instr_i into a control bundle.
   // Opcode 0000000 is the only listed encoding with instr_i[1:0] != 2'b11,
   // and it is the bubble, so every other such encoding falls into default.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one
      // unassigned; otherwise synthesis would infer a latch.
      decCtrl    = '0;
      decIllegal = 1'b0;
      decFused   = 1'b0;
      decIsFp    = 1'b0;
      unique case (instr_i[6:0])
         OP_BUBBLE: decCtrl = '0;
         OP_LOAD:   decCtrl = CTRL_LW;
         OP_STORE:  decCtrl = CTRL_SW;
         OP_REG:    decCtrl = CTRL_R;
         OP_BRANCH: decCtrl = CTRL_B;
         OP_IMM:    decCtrl = CTRL_I;
         OP_JAL:    decCtrl = CTRL_JAL;
         OP_AUIPC:  decCtrl = CTRL_AUIPC;
         OP_LUI:    decCtrl = CTRL_LUI;
         OP_JALR:   decCtrl = CTRL_JALR;
         OP_FLW: begin
            decCtrl = CTRL_FLW;
            decIsFp = 1'b1;
         end
         OP_FSW: begin
            decCtrl = CTRL_FSW;
            decIsFp = 1'b1;
         end
         OP_FP: begin
            decCtrl = CTRL_FP;
            decIsFp = 1'b1;
         end
         OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
            decCtrl  = CTRL_FP;
            decIsFp  = 1'b1;
            decFused = 1'b1;
         end
         default: decIllegal = 1'b1;
      endcase
      // Without the F extension every FP opcode is treated as unsupported
      if (decIsFp && !FP_EN) begin
         decCtrl    = '0;
         decIllegal = 1'b1;
         decFused   = 1'b0;
      end
   end

   assign decSplit = decFused && FUSED_SPLIT;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; flush overrides every other input and SPLIT progress
   always_comb begin
      nextState = state;
      if (flush) begin
         nextState = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_valid) nextState = decSplit ? SPLIT : FULL;
            end
            FULL: begin
               if (out_ready) begin
                  if (in_valid) nextState = decSplit ? SPLIT : FULL;
                  else          nextState = EMPTY;
               end
            end
            SPLIT: begin
               if (out_ready) nextState = FULL;
            end
            default: nextState = EMPTY;
         endcase
      end
   end

   // Output logic: acceptance handshake and the register update qualifiers
   always_comb begin
      inReadyInt   = !flush && ((state == EMPTY) || ((state == FULL) && out_ready));
      loadNew      = in_valid && inReadyInt;
      advanceSplit = (state == SPLIT) && out_ready && !flush;
   end

   // Output registers: load a new uop, step a cracked op to its second uop,
   // hold while stalled, and clear whenever the sequencer empties
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         outValidQ <= 1'b0;
         ctrlQ     <= '0;
         instrQ    <= '0;
         illegalQ  <= 1'b0;
         fpOpQ     <= FPOP_FUNCT;
         fpNegQ    <= 1'b0;
         uopLastQ  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples the
         // pre-edge values, independent of statement order.
         outValidQ <= (nextState != EMPTY);
         if (nextState == EMPTY) begin
            ctrlQ    <= '0;
            instrQ   <= '0;
            illegalQ <= 1'b0;
            fpOpQ    <= FPOP_FUNCT;
            fpNegQ   <= 1'b0;
            uopLastQ <= 1'b0;
         end else if (loadNew) begin
            ctrlQ    <= decCtrl;
            instrQ   <= instr_i;
            illegalQ <= decIllegal;
            // uop0 of a cracked op is the multiply into the FP temp register
            fpOpQ    <= decSplit ? FPOP_MUL : FPOP_FUNCT;
            fpNegQ   <= 1'b0;
            uopLastQ <= !decSplit;
         end else if (advanceSplit) begin
            // uop1 keeps the bundle and instruction, switches to add/sub
            fpOpQ    <= fusedSub ? FPOP_SUB : FPOP_ADD;
            fpNegQ   <= fusedNeg;
            uopLastQ <= 1'b1;
         end
      end
   end

   assign in_ready   = inReadyInt;
   assign out_valid  = outValidQ;
   assign instr_o    = instrQ;
   assign reg_write  = ctrlQ.regWrite;
   assign imm_src    = ctrlQ.immSrc;
   assign alu_src_a  = ctrlQ.aluSrcA;
   assign alu_src_b  = ctrlQ.aluSrcB;
   assign mem_write  = ctrlQ.memWrite;
   assign result_src = ctrlQ.resultSrc;
   assign branch     = ctrlQ.branch;
   assign alu_op     = ctrlQ.aluOp;
   assign jump       = ctrlQ.jump;
   assign fp_sel     = ctrlQ.fpSel;
   assign illegal    = illegalQ;
   assign fp_op      = fpOpQ;
   assign fp_neg     = fpNegQ;
   assign uop_last   = uopLastQ;

endmodule

// File: tb/tb_decode_uop_sequencer.sv
// Self-checking bench for decode_uop_sequencer. Three instances share one input
// stream: (FP_EN,FUSED_SPLIT) = (1,1), (1,0), (0,1). A per-instance queue of
// expected uops, built from the decode table, predicts every output.
module tb_decode_uop_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        inValid;
   logic        outReady;
   logic [31:0] instrIn;

   logic [2:0]        outValidV;
   logic [2:0]        inReadyV;
   logic [2:0][51:0]  obsV;

   int nComp = 0;
   int nFail = 0;

   // Expected uop: {instr, 15-bit bundle, illegal, fp_op, fp_neg, uop_last}
   logic [51:0] mq[3][2];
   int          mcnt[3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gDut
      logic        inReady, outValid;
      logic [31:0] instrO;
      logic        regWrite, memWrite, branch, jump, aluSrcA, fpSel;
      logic        fpNeg, uopLast, illegal;
      logic [2:0]  immSrc;
      logic [1:0]  aluSrcB, resultSrc, aluOp, fpOp;

      decode_uop_sequencer #(.FP_EN(g != 2), .FUSED_SPLIT(g != 1)) dut (
         .clk(clk), .reset_n(reset_n), .flush(flush),
         .in_valid(inValid), .in_ready(inReady), .instr_i(instrIn),
         .out_valid(outValid), .out_ready(outReady), .instr_o(instrO),
         .reg_write(regWrite), .mem_write(memWrite), .branch(branch),
         .jump(jump), .alu_src_a(aluSrcA), .fp_sel(fpSel),
         .imm_src(immSrc), .alu_src_b(aluSrcB), .result_src(resultSrc),
         .alu_op(aluOp), .fp_op(fpOp), .fp_neg(fpNeg),
         .uop_last(uopLast), .illegal(illegal)
      );

      assign outValidV[g] = outValid;
      assign inReadyV[g]  = inReady;
      assign obsV[g] = {instrO, regWrite, immSrc, aluSrcA, aluSrcB, memWrite,
                        resultSrc, branch, aluOp, jump, fpSel,
                        illegal, fpOp, fpNeg, uopLast};
   end

   task automatic check(input string tag, input int inst,
                        input logic [51:0] obs, input logic [51:0] exp);
      nComp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s[inst %0d]: observed %h expected %h", tag, inst, obs, exp);
      end
   endtask

   // Expected uop(s) for one accepted instruction, from the documented table
   function automatic void expand(input logic [31:0] ins, input bit fpEn, input bit split,
                                  output logic [51:0] u0, output logic [51:0] u1,
                                  output int n);
      logic [14:0] b;
      logic [6:0]  op;
      logic [1:0]  kind;
      bit          legal, isFp, fused;
      op = ins[6:0];
      b = '0; legal = 1; isFp = 0; fused = 0;
      case (op)
         7'b0000000: b = '0;
         7'b0000011: b = 15'b1_000_0_01_0_01_0_00_0_0;
         7'b0100011: b = 15'b0_001_0_01_1_00_0_00_0_0;
         7'b0110011: b = 15'b1_000_0_00_0_00_0_10_0_0;
         7'b1100011: b = 15'b0_010_0_00_0_00_1_01_0_0;
         7'b0010011: b = 15'b1_000_0_01_0_00_0_10_0_0;
         7'b1101111: b = 15'b1_011_0_00_0_10_0_00_1_0;
         7'b0010111: b = 15'b1_100_1_10_0_00_0_00_0_0;
         7'b0110111: b = 15'b1_100_1_01_0_00_0_00_0_0;
         7'b1100111: b = 15'b1_000_0_01_0_10_0_00_1_0;
         7'b0000111: begin b = 15'b1_000_0_01_0_01_0_00_0_1; isFp = 1; end
         7'b0100111: begin b = 15'b0_001_0_01_1_00_0_00_0_1; isFp = 1; end
         7'b1010011: begin b = 15'b1_000_0_00_0_00_0_10_0_1; isFp = 1; end
         7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
            b = 15'b1_000_0_00_0_00_0_10_0_1; isFp = 1; fused = 1;
         end
         default: legal = 0;
      endcase
      if (isFp && !fpEn) legal = 0;
      u1 = '0;
      if (!legal) begin
         u0 = {ins, 15'b0, 1'b1, 2'b00, 1'b0, 1'b1};
         n = 1;
      end else if (fused && split) begin
         kind = ins[3:2];  // 00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
         u0 = {ins, b, 1'b0, 2'b01, 1'b0, 1'b0};
         u1 = {ins, b, 1'b0, (kind == 2'b00 || kind == 2'b11) ? 2'b10 : 2'b11, kind[1], 1'b1};
         n = 2;
      end else begin
         u0 = {ins, b, 1'b0, 2'b00, 1'b0, 1'b1};
         n = 1;
      end
   endfunction

   // One clock of stimulus: check registered outputs, apply inputs, check
   // in_ready, then advance the expected-uop queues across the coming edge.
   task automatic cycle(input bit fl, input bit iv, input logic [31:0] ins,
                        input bit ordy, input string tag);
      logic [51:0] u0, u1;
      int          n;
      bit          expRdy;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check({tag, ".out_valid"}, i, 52'(outValidV[i]), 52'(mcnt[i] > 0));
         if (mcnt[i] > 0) check({tag, ".uop"}, i, obsV[i], mq[i][0]);
      end
      flush = fl; inValid = iv; instrIn = ins; outReady = ordy;
      #1;
      for (int i = 0; i < 3; i++) begin
         expRdy = !fl && (mcnt[i] == 0 || (mcnt[i] == 1 && ordy));
         check({tag, ".in_ready"}, i, 52'(inReadyV[i]), 52'(expRdy));
         if (fl) begin
            mcnt[i] = 0;
         end else begin
            if (mcnt[i] > 0 && ordy) begin
               mq[i][0] = mq[i][1];
               mcnt[i]--;
            end
            if (iv && expRdy) begin
               expand(ins, i != 2, i != 1, u0, u1, n);
               mq[i][0] = u0; mq[i][1] = u1; mcnt[i] = n;
            end
         end
      end
   endtask

   // Asynchronous reset between clock edges: outputs must clear at once
   task automatic asyncReset(input string tag);
      @(negedge clk);
      reset_n = 1'b0; flush = 0; inValid = 0; outReady = 0; instrIn = '0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check({tag, ".out_valid"}, i, 52'(outValidV[i]), 52'd0);
         check({tag, ".outputs"}, i, obsV[i], 52'd0);
         mcnt[i] = 0;
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic [31:0] randInstr();
      logic [6:0] ops[18] = '{7'b0000000, 7'b0000011, 7'b0100011, 7'b0110011,
                              7'b1100011, 7'b0010011, 7'b1101111, 7'b0010111,
                              7'b0110111, 7'b1100111, 7'b0000111, 7'b0100111,
                              7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011,
                              7'b1001111, 7'b1111111};
      logic [31:0] r;
      int unsigned sel;
      r = $urandom;
      sel = $urandom_range(0, 19);
      if (sel < 18) r[6:0] = ops[sel];
      else if (sel == 18) r[1:0] = 2'b01;
      return r;
   endfunction

   initial begin
      reset_n = 1'b0; flush = 0; inValid = 0; outReady = 0; instrIn = '0;
      for (int i = 0; i < 3; i++) mcnt[i] = 0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check("reset.out_valid", i, 52'(outValidV[i]), 52'd0);
         check("reset.outputs", i, obsV[i], 52'd0);
      end
      reset_n = 1'b1;

      // lw with consumer ready
      cycle(0, 1, 32'h00012083, 1, "lw");
      cycle(0, 0, 32'h0, 1, "lw.out");
      cycle(0, 0, 32'h0, 1, "idle");

      // FMADD cracked into mul then add
      cycle(0, 1, 32'h003100C3, 1, "fmadd");
      cycle(0, 1, 32'h00012083, 1, "fmadd.uop0");
      cycle(0, 0, 32'h0, 1, "fmadd.uop1");
      cycle(0, 0, 32'h0, 1, "fmadd.drain");

      // FNMSUB stalled three cycles, then released
      cycle(0, 1, 32'h0031004B, 0, "fnmsub");
      repeat (3) cycle(0, 0, 32'h0, 0, "fnmsub.hold");
      cycle(0, 0, 32'h0, 1, "fnmsub.rel0");
      cycle(0, 0, 32'h0, 1, "fnmsub.rel1");
      cycle(0, 0, 32'h0, 1, "fnmsub.empty");

      // Illegal opcode, FLW, misaligned low bits, bubble
      cycle(0, 1, 32'h0000007F, 1, "ill7f");
      cycle(0, 1, 32'h00012007, 1, "flw");
      cycle(0, 1, 32'h00012081, 1, "low01");
      cycle(0, 1, 32'h12345000, 1, "bubble");
      cycle(0, 0, 32'h0, 1, "ill.drain");

      // Four back-to-back R-types
      cycle(0, 1, 32'h002081B3, 1, "rstream0");
      cycle(0, 1, 32'h40418233, 1, "rstream1");
      cycle(0, 1, 32'h005272B3, 1, "rstream2");
      cycle(0, 1, 32'h00630333, 1, "rstream3");
      cycle(0, 0, 32'h0, 1, "rstream.last");
      cycle(0, 0, 32'h0, 1, "rstream.empty");

      // Flush in SPLIT while a new instruction is offered
      cycle(0, 1, 32'h003100C7, 0, "fmsub");
      cycle(1, 1, 32'h00012083, 1, "flush.split");
      cycle(0, 0, 32'h0, 1, "flush.after");

      // Asynchronous reset mid-SPLIT
      cycle(0, 1, 32'h003100CF, 0, "fnmadd");
      cycle(0, 0, 32'h0, 0, "fnmadd.uop0");
      asyncReset("reset.split");
      cycle(0, 0, 32'h0, 1, "reset.after");

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, randInstr(),
               $urandom_range(0, 9) < 7, "rand");
      end
      cycle(0, 0, 32'h0, 1, "final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
      $finish;
   end

endmodule
